// File: rtl/frame_dispatch_if.sv
// Framebuffer read port plus outbound word stream of the frame dispatcher.
// The master side issues reads and drives the stream; the slave side is the memory and the serializer.
interface frame_dispatch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_rd_en;
  logic [DATA_W-1:0] fb_rd_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_sof;
  logic              m_eol;
  logic              m_eof;

  modport master (
    output fb_addr, fb_rd_en, m_data, m_valid, m_sof, m_eol, m_eof,
    input  fb_rd_data, m_ready
  );

  modport slave (
    input  fb_addr, fb_rd_en, m_data, m_valid, m_sof, m_eol, m_eof,
    output fb_rd_data, m_ready
  );
endinterface

// File: rtl/frame_dispatch_unit.sv
// Frame dispatcher: synchronizes an async frame request, reads one frame word by word
// from a 1-cycle-latency framebuffer and streams it out with SOF/EOL/EOF markers.
module frame_dispatch_unit #(
  parameter int H_WORDS = 160,
  parameter int V_LINES = 144,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_req,
  frame_dispatch_if.master        bus,
  output logic                    busy,
  output logic                    frame_done,
  output logic [7:0]              frames_dropped
);

  localparam int XW = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_WORDS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

  state_t            state_q, state_d;
  logic              s1, s2, s3;
  logic              req_pulse;
  logic [ADDR_W-1:0] addr_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q, sof_q, eol_q, eof_q;
  logic              done_q;
  logic [7:0]        dropped_q;
  logic              handshake;

  // frame_req is asynchronous to clk: two flops for metastability, a third for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      s1 <= frame_req;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign req_pulse = s2 & ~s3;
  assign handshake = valid_q & bus.m_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_pulse) state_d = FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    if (handshake) state_d = eof_q ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.fb_rd_en = (state_q == FETCH);
    bus.fb_addr  = (state_q == FETCH) ? addr_q : '0;
    busy         = (state_q != IDLE);
  end

  // Position counters and the registered stream word; flags are only ever set alongside valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_pulse) begin
            addr_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
          end
        end
        LOAD: begin
          data_q  <= bus.fb_rd_data;
          valid_q <= 1'b1;
          sof_q   <= (x_q == '0) && (y_q == '0);
          eol_q   <= (x_q == X_LAST);
          eof_q   <= (x_q == X_LAST) && (y_q == Y_LAST);
        end
        SEND: begin
          if (handshake) begin
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            if (eof_q) begin
              done_q <= 1'b1;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
              if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= y_q + YW'(1);
              end else begin
                x_q <= x_q + XW'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Requests arriving while a frame is in flight (including the final handshake cycle) are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dropped_q <= '0;
    else if (req_pulse && (state_q != IDLE) && (dropped_q != 8'hFF))
      dropped_q <= dropped_q + 8'd1;
  end

  assign bus.m_data     = data_q;
  assign bus.m_valid    = valid_q;
  assign bus.m_sof      = sof_q;
  assign bus.m_eol      = eol_q;
  assign bus.m_eof      = eof_q;
  assign frame_done     = done_q;
  assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_frame_dispatch_unit.sv
// Directed bench for frame_dispatch_unit on a 4x2 frame whose framebuffer word equals its address.
module tb_frame_dispatch_unit;

  localparam int H = 4;
  localparam int V = 2;
  localparam int N_WORDS = H * V;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_req = 1'b0;
  logic       busy;
  logic       frame_done;
  logic [7:0] frames_dropped;

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  logic [15:0] words[$];
  logic [2:0]  flags[$];
  logic        stall_prev = 1'b0;
  logic [15:0] held_data = '0;
  logic [2:0]  held_flags = '0;

  frame_dispatch_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  frame_dispatch_unit #(.H_WORDS(H), .V_LINES(V), .DATA_W(16), .ADDR_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_req      (frame_req),
    .bus            (bus),
    .busy           (busy),
    .frame_done     (frame_done),
    .frames_dropped (frames_dropped)
  );

  always #5 clk = ~clk;

  // Framebuffer model: one-cycle read latency, word = address.
  always @(posedge clk) begin
    if (bus.fb_rd_en) bus.fb_rd_data <= 16'(bus.fb_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream monitor, sampled on the falling edge where inputs and outputs are settled.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.fb_rd_en) rd_cnt++;
      if (frame_done) begin
        done_cnt++;
        check("done_in_idle", 32'(busy), 32'd0);
      end
      if (!bus.m_valid) check("flags_without_valid", 32'({bus.m_sof, bus.m_eol, bus.m_eof}), 32'd0);
      if (stall_prev) begin
        check("stall_hold_data", 32'(bus.m_data), 32'(held_data));
        check("stall_hold_flags", 32'({bus.m_sof, bus.m_eol, bus.m_eof}), 32'(held_flags));
        check("stall_hold_valid", 32'(bus.m_valid), 32'd1);
      end
      if (bus.m_valid && bus.m_ready) begin
        words.push_back(bus.m_data);
        flags.push_back({bus.m_sof, bus.m_eol, bus.m_eof});
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      held_data  = bus.m_data;
      held_flags = {bus.m_sof, bus.m_eol, bus.m_eof};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    words.delete();
    flags.delete();
    rd_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_req(input int width);
    frame_req = 1'b1;
    repeat (width) tick();
    frame_req = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_dropped"}, 32'(frames_dropped), 32'd0);
    check({tag, "_rd_en"}, 32'(bus.fb_rd_en), 32'd0);
    check({tag, "_addr"}, 32'(bus.fb_addr), 32'd0);
    check({tag, "_valid"}, 32'(bus.m_valid), 32'd0);
    check({tag, "_data"}, 32'(bus.m_data), 32'd0);
    check({tag, "_flags"}, 32'({bus.m_sof, bus.m_eol, bus.m_eof}), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!frame_done && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done_timeout"}, 32'(frame_done), 32'd1);
    tick();
  endtask

  task automatic check_frame(input string tag);
    int n = words.size();
    check({tag, "_word_count"}, 32'(n), 32'(N_WORDS));
    for (int i = 0; i < n && i < N_WORDS; i++) begin
      logic [2:0] exp_f;
      exp_f = {i == 0, (i % H) == H - 1, i == N_WORDS - 1};
      check({tag, "_data"}, 32'(words[i]), 32'(i));
      check({tag, "_flags"}, 32'(flags[i]), 32'(exp_f));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int k;
    bus.m_ready = 1'b1;
    bus.fb_rd_data = '0;

    // Reset state
    #1;
    check_outputs_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_outputs_zero("post_reset");

    // Basic frame with latency measurement: frame_req first sampled at edge N
    clear_log();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    k = 0;
    while (!bus.m_valid && k < 20) begin
      tick();
      k++;
    end
    check("basic_valid_latency", 32'(k), 32'd4);
    wait_done("basic", 100);
    repeat (5) tick();
    check_frame("basic");
    check("basic_rd_cnt", 32'(rd_cnt), 32'(N_WORDS));
    check("basic_done_cnt", 32'(done_cnt), 32'd1);
    check("basic_dropped", 32'(frames_dropped), 32'd0);

    // Backpressure with random ready
    clear_log();
    pulse_req(1);
    k = 0;
    while (!frame_done && k < 500) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    check("bp_done_timeout", 32'(frame_done), 32'd1);
    bus.m_ready = 1'b1;
    repeat (5) tick();
    check_frame("bp");
    check("bp_rd_cnt", 32'(rd_cnt), 32'(N_WORDS));
    check("bp_done_cnt", 32'(done_cnt), 32'd1);

    // Requests while busy: one mid-frame, one landing on the last handshake
    clear_log();
    pulse_req(1);
    repeat (8) tick();
    pulse_req(1);
    k = 0;
    while (!(bus.m_valid && bus.m_eof) && k < 100) begin
      tick();
      k++;
    end
    check("busy_reach_eof", 32'(bus.m_eof), 32'd1);
    bus.m_ready = 1'b0;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    tick();
    bus.m_ready = 1'b1;
    tick();
    check("busy_last_done", 32'(frame_done), 32'd1);
    repeat (15) tick();
    check("busy_no_restart", 32'(busy), 32'd0);
    check_frame("busy");
    check("busy_rd_cnt", 32'(rd_cnt), 32'(N_WORDS));
    check("busy_done_cnt", 32'(done_cnt), 32'd1);
    check("busy_dropped", 32'(frames_dropped), 32'd2);

    // Saturation of the drop counter while stalled in SEND
    do_reset();
    check("sat_dropped_cleared", 32'(frames_dropped), 32'd0);
    clear_log();
    bus.m_ready = 1'b0;
    pulse_req(1);
    k = 0;
    while (!bus.m_valid && k < 20) begin
      tick();
      k++;
    end
    check("sat_in_send", 32'(bus.m_valid), 32'd1);
    for (int i = 0; i < 300; i++) begin
      pulse_req(1);
      tick();
      tick();
    end
    repeat (3) tick();
    check("sat_busy", 32'(busy), 32'd1);
    check("sat_dropped", 32'(frames_dropped), 32'd255);
    bus.m_ready = 1'b1;
    wait_done("sat", 100);

    // Reset mid-frame after word 3
    do_reset();
    clear_log();
    pulse_req(1);
    k = 0;
    while (words.size() < 4 && k < 100) begin
      tick();
      k++;
    end
    check("rst_mid_words", 32'(words.size()), 32'd4);
    reset = 1'b1;
    #1;
    check_outputs_zero("rst_mid");
    tick();
    reset = 1'b0;
    tick();
    check_outputs_zero("rst_mid_after");
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);
    clear_log();
    pulse_req(1);
    wait_done("rst_restart", 100);
    repeat (5) tick();
    check_frame("rst_restart");

    // Wide request: ten clocks high gives exactly one frame
    clear_log();
    pulse_req(10);
    wait_done("wide", 100);
    repeat (20) tick();
    check_frame("wide");
    check("wide_done_cnt", 32'(done_cnt), 32'd1);
    check("wide_rd_cnt", 32'(rd_cnt), 32'(N_WORDS));
    check("wide_dropped", 32'(frames_dropped), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/frame_dispatch_unit.md
# frame_dispatch_unit

Consumer end of the frame-timing handshake. It takes the `send_frame` pulse, which is generated in the pre-clock domain, into the `clk` domain. On each accepted request it reads one full frame from the synchronous framebuffer, word by word. It emits the words on a valid/ready stream with start-of-frame, end-of-line and end-of-frame markers, for the display/link transmitter. It sits between the frame timing logic, the framebuffer read port and the output serializer.

## Interface
- `H_WORDS`, default 160: words per line.
- `V_LINES`, default 144: lines per frame.
- `DATA_W`, default 16: framebuffer and stream word width.
- `ADDR_W`, default 15: framebuffer address width; must satisfy 2^ADDR_W ≥ H_WORDS·V_LINES.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `frame_req`  in  1  frame request pulse from another clock domain, asynchronous to clk; at least 1 clk period wide.
- `fb_addr`  out  ADDR_W  framebuffer read address.
- `fb_rd_en`  out  1  framebuffer read strobe.
- `fb_rd_data`  in  DATA_W  read data, valid exactly 1 cycle after `fb_rd_en`.
- `m_data`  out  DATA_W  stream word.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  downstream accept.
- `m_sof`  out  1  current word is the first word of the frame.
- `m_eol`  out  1  current word is the last word of a line.
- `m_eof`  out  1  current word is the last word of the frame.
- `busy`  out  1  frame transfer in progress.
- `frame_done`  out  1  1-cycle pulse after the final word handshake.
- `frames_dropped`  out  8  count of requests rejected while busy; saturating.

## Operation
- **Request capture**
  - `frame_req` passes through a 2-flop synchronizer (s1, s2) and a history flop s3, all reset to 0.
  - `req_pulse = s2 & ~s3`.
  - A request level that is high at reset release counts as one request.
- **FSM states:** IDLE, FETCH, LOAD, SEND.
  - IDLE: if `req_pulse`, clear addr, x and y, then go to FETCH.
  - FETCH: `fb_rd_en=1`, `fb_addr=addr`; go to LOAD.
  - LOAD: register `fb_rd_data` into `m_data`; register the flags; set `m_valid=1`; go to SEND.
  - SEND: hold `m_data`, flags and `m_valid` until `m_valid & m_ready`.
    - On handshake, clear `m_valid`.
    - If the word was last (`m_eof`): go to IDLE and pulse `frame_done`.
    - Otherwise: addr+1; x+1, or x=0 and y+1 when x==H_WORDS-1; go to FETCH.
- **Flags,** computed at LOAD from the current x, y:
  - `m_sof` = (x==0 && y==0).
  - `m_eol` = (x==H_WORDS-1).
  - `m_eof` = `m_eol` && (y==V_LINES-1).
  - All flags are 0 whenever `m_valid=0`.
- `busy = (state != IDLE)`.
- **Dropped requests:**
  - A `req_pulse` while state≠IDLE increments `frames_dropped`, saturating at 255; the request is discarded.
  - This includes the cycle of the final handshake, because state is still SEND.
  - `frames_dropped` is cleared only by reset.
- Address never wraps within a frame; the last address is H_WORDS·V_LINES−1.
- `m_ready` is ignored while `m_valid=0`.

## Timing
- **Reset values:** all outputs 0; state IDLE; s1, s2, s3 = 0; counters 0.
- **Reset mid-frame:** immediate abort, no `m_eof` and no `frame_done`; the next request restarts at addr 0.
- **Request-to-read latency:** `frame_req` first sampled high at edge N gives `req_pulse` between N+1 and N+2. FETCH starts after N+2 (`fb_rd_en` high that cycle). `m_valid` rises after N+4.
- **Throughput:** 1 word per 3 cycles with `m_ready` held high; frame length is 3·H_WORDS·V_LINES cycles minimum.
- **Backpressure:** with `m_ready` low, all stream outputs hold stable; no new framebuffer read is issued.
- `frame_done` is high exactly 1 cycle, in the IDLE cycle after the last handshake.
- **Request pulse width:** a request wider than 1 clk still yields a single `req_pulse`. A new request requires `frame_req` to return low for at least 2 clk cycles.

## Test plan
- **Basic frame:** H_WORDS=4, V_LINES=2, framebuffer word = address, `m_ready`=1, one `frame_req` pulse.
  - Stream 0..7.
  - `m_sof` on word 0; `m_eol` on words 3 and 7; `m_eof` on word 7.
  - `frame_done` once; `m_valid` first rises 4 edges after the first sample.
- **Backpressure:** toggle `m_ready` randomly during a frame.
  - Same 8 words in order, none duplicated or lost.
  - `m_data` and flags stable while `m_valid & ~m_ready`.
  - `fb_rd_en` asserted exactly 8 times.
- **Request while busy:** a second `frame_req` mid-frame, and a third in the last-handshake cycle.
  - `frames_dropped`=2; the current frame completes unaffected; no second frame starts.
- **Saturation:** 300 requests while `m_ready`=0 holds the FSM in SEND.
  - `frames_dropped`=255.
- **Reset mid-frame:** assert reset after word 3.
  - All outputs 0 immediately.
  - The next request streams from word 0 with `m_sof`=1.
- **Wide request:** `frame_req` high for 10 clk cycles.
  - Exactly one frame is sent and `frames_dropped` stays 0.
